uart_tx_ctrl: RTL
=================

// Module: uart_tx_ctrl
// PURPOSE
//  MMIO-mapped UART transmit controller on the OTTER IOBUS.
//  - Buffers CPU byte writes in a FIFO and serialises them 8N1 on TX.
//  - Exposes a status word at the RDY address for software polling.
//  - Decodes IOBUS_ADDR itself; the wrapper ORs STATUS_RD into IOBUS_IN.
// PARAMETERS
//  CLK_HZ      50_000_000    sclk frequency in Hz
//  BAUD        115200        line rate in bits/s
//  FIFO_DEPTH  16            TX FIFO entries; power of 2, >= 2
//  DATA_AD     32'h11180000  write address: byte to transmit
//  RDY_AD      32'h111C0000  read: status word; write: clear sticky bits
// PORTS
//  CLK         in   1   system clock (sclk)
//  RESET       in   1   synchronous reset, active-high
//  IOBUS_ADDR  in   32  MCU IOBUS address
//  IOBUS_OUT   in   32  MCU write data
//  IOBUS_WR    in   1   MCU write strobe, one cycle per store
//  STATUS_RD   out  32  status word when IOBUS_ADDR==RDY_AD, else 0 (combinational)
//  TX          out  1   serial line, idles high
//  BUSY        out  1   1 while a frame is in flight or the FIFO is non-empty
//  TX_IRQ      out  1   drain interrupt pulse (see CONFIGURATION)
// BEHAVIOUR
//  Clock, reset and register values:
//  - One clock (CLK). Reset is synchronous and active-high (RESET).
//  - Reset values: TX=1, BUSY=0, TX_IRQ=0, FIFO empty, overflow=0, FSM=IDLE.
//  Status word:
//  - bit0 = ~full, bit1 = empty, bit2 = overflow (sticky), bit3 = frame active.
//  - bits[31:4] = 0.
//  Push (IOBUS_WR && IOBUS_ADDR==DATA_AD):
//  - Pushes IOBUS_OUT[7:0]; IOBUS_OUT[31:8] is ignored.
//  - Accepted if not full, or if full and a pop occurs in the same cycle.
//  - Otherwise the byte is dropped and overflow is set.
//  Clear (IOBUS_WR && IOBUS_ADDR==RDY_AD && IOBUS_OUT[2]):
//  - Clears overflow.
//  - Set wins over clear in the same cycle; it cannot coincide anyway, since
//    the two operations decode different addresses.
//  Baud divisor:
//  - DIV = (CLK_HZ + BAUD/2) / BAUD, computed at elaboration.
//  - The counter is $clog2(DIV) bits wide, counts 0..DIV-1 and wraps.
//  - Elaboration error if DIV < 2.
//  FSM:
//  - IDLE:  if FIFO non-empty, pop into the shift register, clear the counter,
//           go to START.
//  - START: TX=0 for DIV cycles, then go to DATA with bit index 0.
//  - DATA:  TX=shreg[idx], LSB first, each bit held DIV cycles.
//           After idx==7, go to STOP.
//  - STOP:  TX=1 for DIV cycles, then go to IDLE.
//  - From STOP there is no gap beyond the single IDLE cycle. The inter-frame
//    idle is exactly 1 cycle at TX=1.
//  Latency:
//  - Write accepted at edge E into an empty FIFO with FSM in IDLE: pop at
//    edge E+1, and TX falls after edge E+1.
//  - Frame length is 10*DIV cycles; back-to-back period is 10*DIV+1 cycles.
//  Boundaries:
//  - Full and empty flags derive from a count of width $clog2(FIFO_DEPTH)+1.
//  - Read and write pointers wrap modulo FIFO_DEPTH.
//  - Push into an empty FIFO while IDLE is not forwarded in the same cycle.
//    It is always popped on the next edge.
//  - RESET mid-frame aborts the frame: TX=1 on the next edge, FIFO flushed.
//  - Unmapped addresses: no effect; STATUS_RD=0.
// CONFIGURATION
//  UART_TX_IRQ_EN defined:
//  - TX_IRQ pulses high for exactly 1 cycle on the edge where the FSM enters
//    IDLE from STOP with the FIFO empty (last queued byte fully sent).
//  UART_TX_IRQ_EN undefined:
//  - TX_IRQ is tied 0 and no IRQ logic is built.
//  - All other behaviour is identical.
// STRUCTURE
//  Package uart_pkg:
//  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t
//  - localparams for status bit indices (ST_NOTFULL=0, ST_EMPTY=1, ST_OVF=2,
//    ST_ACTIVE=3)
//  - default DATA_AD / RDY_AD address constants
//  Sub-module sync_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH):
//  - single-clock FIFO with push, pop, dout, full, empty
//  - synchronous reset
//  - same-cycle push+pop allowed when full
//  Top level holds: address decode, overflow flag, baud counter, FSM,
//  shift register, IRQ.
// TESTING
//  Bench uses CLK_HZ=16, BAUD=1, so DIV=16.
//  1. Write 8'hA5 to DATA_AD -> TX low 16 cycles, then bits 1,0,1,0,0,1,0,1,
//     stop bit 1; 160 cycles total; BUSY drops after the stop bit.
//  2. Write 17 bytes 0x00..0x10 back-to-back at FIFO_DEPTH=16 while TX is
//     idle -> first is popped so all 17 accepted; 18th write sets status
//     bit2; transmitted order is 0x00..0x10 with a 161-cycle period.
//  3. Fill FIFO, read RDY_AD -> STATUS_RD=32'h8 (not-full=0, active=1);
//     write 32'h4 to RDY_AD after overflow -> bit2 clears.
//  4. Assert RESET 40 cycles into a frame -> TX=1 next edge, STATUS_RD at
//     RDY_AD = 32'h3, no further frames emitted.
//  5. With UART_TX_IRQ_EN, send 2 bytes -> exactly one TX_IRQ pulse,
//     1 cycle wide, at cycle 321 after the pop; without the macro TX_IRQ
//     stays 0.
//  6. Write to unrelated address 32'h11080000 -> no push, STATUS_RD=0,
//     TX stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller.
// Holds the FSM state encoding, status-word bit positions and default MMIO addresses.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int ST_NOTFULL = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_ACTIVE  = 3;

    localparam logic [31:0] DEF_DATA_AD = 32'h11180000;
    localparam logic [31:0] DEF_RDY_AD  = 32'h111C0000;

    // Rounded clocks-per-bit divisor.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_fifo.sv
// Single-clock FIFO buffering bytes for the UART transmitter.
// Synchronous reset; a push while full is accepted when a pop happens in the same cycle.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;
    logic             w_push, w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_dout  = r_mem[r_rptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    // Pointers are exactly AW bits, so DEPTH being a power of two makes them wrap for free.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// MMIO UART transmitter: FIFO-buffered byte writes sent 8N1 on TX, with a pollable status word.
// Define UART_TX_IRQ_EN to build the drain interrupt on TX_IRQ; otherwise TX_IRQ is tied low.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] DATA_AD    = DEF_DATA_AD,
    parameter logic [31:0] RDY_AD     = DEF_RDY_AD
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] STATUS_RD,
    output logic        TX,
    output logic        BUSY,
    output logic        TX_IRQ
);
    localparam int             DIV    = baud_div(CLK_HZ, BAUD);
    localparam int             CW     = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0]  DIV_M1 = CW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx_ctrl: baud divisor must be at least 2");
        end
    endgenerate

    tx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shreg;
    logic          r_tx, r_ovf;
    logic          w_full, w_empty, w_pop, w_wr_data, w_wr_clr, w_bit_end;
    logic [7:0]    w_dout;
    logic          w_unused_ok;

    assign w_wr_data   = IOBUS_WR && (IOBUS_ADDR == DATA_AD);
    assign w_wr_clr    = IOBUS_WR && (IOBUS_ADDR == RDY_AD) && IOBUS_OUT[ST_OVF];
    assign w_pop       = (r_state == IDLE) && !w_empty;
    assign w_bit_end   = (r_cnt == DIV_M1);
    assign w_unused_ok = &{1'b0, IOBUS_OUT[31:8]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_push  (w_wr_data),
        .i_pop   (w_pop),
        .i_din   (IOBUS_OUT[7:0]),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge CLK) begin
        if (RESET)                              r_ovf <= 1'b0;
        else if (w_wr_data && w_full && !w_pop) r_ovf <= 1'b1;
        else if (w_wr_clr)                      r_ovf <= 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: if (w_pop) begin
                    r_shreg <= w_dout;
                    r_cnt   <= '0;
                    r_tx    <= 1'b0;
                    r_state <= START;
                end
                START: if (w_bit_end) begin
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_tx    <= r_shreg[0];
                    r_state <= DATA;
                end else r_cnt <= r_cnt + 1'b1;
                DATA: if (w_bit_end) begin
                    r_cnt <= '0;
                    if (r_idx == 3'd7) begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                        r_tx  <= r_shreg[r_idx + 3'd1];
                    end
                end else r_cnt <= r_cnt + 1'b1;
                STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef UART_TX_IRQ_EN
    logic r_irq;
    // A push landing on the final stop cycle means the queue is not drained, so no pulse.
    always_ff @(posedge CLK) begin
        if (RESET) r_irq <= 1'b0;
        else       r_irq <= (r_state == STOP) && w_bit_end && w_empty && !w_wr_data;
    end
    assign TX_IRQ = r_irq;
`else
    assign TX_IRQ = 1'b0;
`endif

    always_comb begin
        STATUS_RD = '0;
        if (IOBUS_ADDR == RDY_AD) begin
            STATUS_RD[ST_NOTFULL] = ~w_full;
            STATUS_RD[ST_EMPTY]   = w_empty;
            STATUS_RD[ST_OVF]     = r_ovf;
            STATUS_RD[ST_ACTIVE]  = (r_state != IDLE);
        end
    end

    assign TX   = r_tx;
    assign BUSY = (r_state != IDLE) || !w_empty;

endmodule
